// File: rtl/sseg_scan_if.sv
// Load/display bundle between the board wrapper and the seven-segment scanner.
// ld is a one-cycle strobe with no back-pressure: every ld is accepted and captured
// (last write wins); busy stays high from that capture until the value reaches the display.
interface sseg_scan_if;
    logic        ld;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  dbg_dig;

    modport master (
        output ld, data_in, dp_in,
        input  busy, an, seg, dp, dbg_dig
    );

    modport slave (
        input  ld, data_in, dp_in,
        output busy, an, seg, dp, dbg_dig
    );
endinterface

// File: rtl/sseg_scan.sv
// Multiplexed 4-digit hex display driver: scans one digit per rising edge of sclk,
// swaps in a newly loaded value only at frame boundaries, and blanks leading zeros.
module sseg_scan #(
    parameter bit LEAD_BLANK     = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    sseg_scan_if.slave  bus
);

    localparam logic [3:0] AN_DARK  = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_DARK  = SEG_ACTIVE_LOW;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic        sclk_q;
    logic [1:0]  dig_q, dig_d;
    logic        lit_q, lit_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic [15:0] pend_q, pend_d;
    logic [3:0]  pend_dp_q, pend_dp_d;
    logic        busy_q, busy_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        tick;
    logic        frame_end;
    logic [1:0]  nxt;
    logic [15:0] upper;
    logic        blank;
    logic        dp_lit;
    logic [3:0]  an_lo;
    logic [6:0]  seg_lo;

    always_comb begin
        tick      = sclk & ~sclk_q;
        frame_end = tick & (dig_q == 2'd3);

        dig_d     = dig_q;
        lit_d     = lit_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        busy_d    = busy_q;
        an_d      = an_q;
        seg_d     = seg_q;
        dp_d      = dp_q;

        // Transfer uses the pending value from before this cycle's ld, so a
        // simultaneous ld always lands in pend and waits for the next frame.
        if (frame_end && busy_q) begin
            disp_d    = pend_q;
            disp_dp_d = pend_dp_q;
            busy_d    = 1'b0;
        end
        if (bus.ld) begin
            pend_d    = bus.data_in;
            pend_dp_d = bus.dp_in;
            busy_d    = 1'b1;
        end

        // The first tick after reset lights digit 0 without advancing, so the
        // scan always starts from the rightmost digit.
        nxt    = lit_q ? dig_q + 2'd1 : dig_q;
        upper  = disp_d >> {nxt, 2'b00};
        blank  = LEAD_BLANK && (nxt != 2'd0) && (upper == 16'h0000);
        dp_lit = disp_dp_d[nxt];
        an_lo  = (blank && !dp_lit) ? 4'hF : ~(4'b0001 << nxt);
        seg_lo = blank ? 7'h7F : decode(disp_d[{nxt, 2'b00} +: 4]);

        if (tick) begin
            dig_d = nxt;
            lit_d = 1'b1;
            an_d  = SEG_ACTIVE_LOW ? an_lo  : ~an_lo;
            seg_d = SEG_ACTIVE_LOW ? seg_lo : ~seg_lo;
            dp_d  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= 1'b0;
            dig_q     <= 2'd0;
            lit_q     <= 1'b0;
            disp_q    <= 16'h0000;
            disp_dp_q <= 4'h0;
            pend_q    <= 16'h0000;
            pend_dp_q <= 4'h0;
            busy_q    <= 1'b0;
            an_q      <= AN_DARK;
            seg_q     <= SEG_DARK;
            dp_q      <= DP_DARK;
        end else begin
            sclk_q    <= sclk;
            dig_q     <= dig_d;
            lit_q     <= lit_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            busy_q    <= busy_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.dbg_dig = dig_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed test-plan scenarios plus a randomized soak, all compared cycle by cycle
// against a digit-position/frame model of the display.
module tb_sseg_scan;

  logic clk = 1'b0;
  logic rst;
  logic sclk;
  sseg_scan_if bus ();

  sseg_scan dut (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  bit          m_prev;
  int          m_dig;
  bit          m_lit;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpm, m_pdp;
  bit          m_busy;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void show_digit(input int n);
    logic [15:0] rest;
    bit blank, lit;
    rest  = m_disp >> (4 * n);
    blank = (n > 0) && (rest == 16'h0);
    lit   = m_dpm[n];
    m_an  = 4'hF;
    if (!blank || lit) m_an[n] = 1'b0;
    m_seg = blank ? 7'h7F : seg_tab[rest[3:0]];
    m_dp  = !lit;
  endfunction

  function automatic void model_step(input bit s, input bit l, input logic [15:0] d,
                                     input logic [3:0] p, input bit r);
    if (r) begin
      m_prev = 0; m_dig = 0; m_lit = 0; m_disp = 0; m_pend = 0;
      m_dpm = 0; m_pdp = 0; m_busy = 0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      return;
    end
    if (s && !m_prev) begin
      if (m_dig == 3 && m_busy) begin
        m_disp = m_pend; m_dpm = m_pdp; m_busy = 0;
      end
      if (m_lit) m_dig = (m_dig + 1) % 4;
      m_lit = 1;
      show_digit(m_dig);
    end
    m_prev = s;
    if (l) begin
      m_pend = d; m_pdp = p; m_busy = 1;
    end
  endfunction

  // Drive one clk cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit s, input bit l = 0, input logic [15:0] d = 16'h0,
                     input logic [3:0] p = 4'h0, input bit r = 0);
    sclk = s; bus.ld = l; bus.data_in = d; bus.dp_in = p; rst = r;
    @(posedge clk);
    model_step(s, l, d, p, r);
    #1;
    check_eq("an",   16'(bus.an),   16'(m_an));
    check_eq("seg",  16'(bus.seg),  16'(m_seg));
    check_eq("dp",   16'(bus.dp),   16'(m_dp));
    check_eq("busy", 16'(bus.busy), 16'(m_busy));
    bus.ld = 1'b0;
  endtask

  // One sclk period ending high; the tick lands on the third cycle.
  task automatic period();
    cyc(0); cyc(0); cyc(1); cyc(1);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] a, input logic [6:0] s,
                            input logic d);
    check_eq({tag, "_an"},  16'(bus.an),  16'(a));
    check_eq({tag, "_seg"}, 16'(bus.seg), 16'(s));
    check_eq({tag, "_dp"},  16'(bus.dp),  16'(d));
  endtask

  initial begin
    bit s;
    sclk = 0; rst = 1; bus.ld = 0; bus.data_in = 0; bus.dp_in = 0;

    // Reset with sclk toggling, then the first tick lights digit 0.
    cyc(1, .r(1)); cyc(0, .r(1));
    expect_out("rst", 4'hF, 7'h7F, 1'b1);
    check_eq("rst_busy", 16'(bus.busy), 16'h0);
    period();
    expect_out("first", 4'hE, 7'h40, 1'b1);

    // Scan order.
    cyc(1, 1, 16'h1234, 4'h0);
    check_eq("ld_busy", 16'(bus.busy), 16'h1);
    period(); period(); period();
    check_eq("wait_busy", 16'(bus.busy), 16'h1);
    period(); expect_out("scan0", 4'hE, 7'h19, 1'b1);
    check_eq("bnd_busy", 16'(bus.busy), 16'h0);
    period(); expect_out("scan1", 4'hD, 7'h30, 1'b1);
    period(); expect_out("scan2", 4'hB, 7'h24, 1'b1);
    period(); expect_out("scan3", 4'h7, 7'h79, 1'b1);

    // Blanking and dp.
    cyc(1, 1, 16'h0005, 4'b0100);
    period(); expect_out("blk0", 4'hE, 7'h12, 1'b1);
    period(); expect_out("blk1", 4'hF, 7'h7F, 1'b1);
    period(); expect_out("blk2", 4'hB, 7'h7F, 1'b0);
    period(); expect_out("blk3", 4'hF, 7'h7F, 1'b1);

    // Tear-free update.
    cyc(1, 1, 16'hAAAA, 4'h0);
    period(); expect_out("tear0", 4'hE, 7'h08, 1'b1);
    period(); expect_out("tear1", 4'hD, 7'h08, 1'b1);
    cyc(1, 1, 16'hFFFF, 4'h0);
    period(); expect_out("tear2", 4'hB, 7'h08, 1'b1);
    period(); expect_out("tear3", 4'h7, 7'h08, 1'b1);
    check_eq("tear_busy", 16'(bus.busy), 16'h1);
    period(); expect_out("tear4", 4'hE, 7'h0E, 1'b1);
    check_eq("tear_drop", 16'(bus.busy), 16'h0);

    // ld coinciding with the boundary tick while idle.
    period(); period(); period();
    cyc(0); cyc(0); cyc(1, 1, 16'h00C0, 4'h0); cyc(1);
    expect_out("sim0", 4'hE, 7'h0E, 1'b1);
    check_eq("sim_busy", 16'(bus.busy), 16'h1);
    period(); period(); period();
    period(); expect_out("simc0", 4'hE, 7'h40, 1'b1);
    period(); expect_out("simc1", 4'hD, 7'h46, 1'b1);
    period(); period();

    // Single-cycle sclk pulse gives exactly one tick.
    for (int i = 0; i < 5; i++) cyc(0);
    cyc(1);
    for (int i = 0; i < 5; i++) cyc(0);
    check_eq("pulse_dig", 16'(bus.dbg_dig), 16'h0);
    expect_out("pulse", 4'hE, 7'h40, 1'b1);

    // Mid-frame reset discards the pending value.
    cyc(0, 1, 16'h1234, 4'hF);
    cyc(1); period();
    check_eq("pre_dig", 16'(bus.dbg_dig), 16'h2);
    cyc(0, .r(1));
    check_eq("mrst_busy", 16'(bus.busy), 16'h0);
    check_eq("mrst_dig", 16'(bus.dbg_dig), 16'h0);
    cyc(0); cyc(0);
    expect_out("mrst_dark", 4'hF, 7'h7F, 1'b1);
    cyc(1);
    expect_out("mrst_d0", 4'hE, 7'h40, 1'b1);
    for (int i = 0; i < 16; i++) cyc(i % 4 >= 2);

    // Randomized soak: irregular sclk, random loads, rare resets.
    s = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      if ($urandom_range(0, 2) == 0) s = ~s;
      d = 16'($urandom) >> (4 * $urandom_range(0, 4));
      cyc(s, $urandom_range(0, 19) == 0, d, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
          $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
